// File: rtl/simon_pkg.sv
// Shared Simon 32/64 definitions: word type, key-schedule constants, round function,
// rotations and the control-state encoding used by the encrypt and decrypt cores.
package simon_pkg;

    localparam int WORD_W = 16;
    localparam logic [WORD_W-1:0] CONST_C = 16'hfffc;
    // z0 sequence; character i of the written sequence lives at bit 61-i.
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXPAND  = 2'd1,
        DECRYPT = 2'd2,
        DONE    = 2'd3
    } state_t;

    function automatic word_t rotl(input word_t v, input int unsigned n);
        return word_t'((v << n) | (v >> (WORD_W - n)));
    endfunction

    function automatic word_t rotr(input word_t v, input int unsigned n);
        return rotl(v, WORD_W - n);
    endfunction

    function automatic word_t simon_f(input word_t v);
        return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
    endfunction

    function automatic logic z_bit(input logic [5:0] idx);
        if (idx > 6'd61) begin
            return 1'b0;
        end
        return Z0[6'd61 - idx];
    endfunction

endpackage

// File: rtl/simon_keysched_step.sv
// One Simon 32/64 key-schedule step, either forward (k[i+4] from k[i..i+3]) or
// inverse (k[j-4] from k[j-3..j]); the inverse reuses the same XOR network.
module simon_keysched_step
    import simon_pkg::*;
(
    input  logic  i_inverse,
    input  word_t i_w3,
    input  word_t i_w2,
    input  word_t i_w1,
    input  word_t i_w0,
    input  logic  i_z,
    output word_t o_new
);

    word_t w_a;
    word_t w_b;
    word_t w_src;
    word_t w_t0;
    word_t w_t1;

    // Inverse: window is {k[j],k[j-1],k[j-2],k[j-3]}, so the roles shift by one word.
    assign w_a   = i_inverse ? i_w2 : i_w3;
    assign w_b   = i_inverse ? i_w0 : i_w1;
    assign w_src = i_inverse ? i_w3 : i_w0;

    assign w_t0  = rotr(w_a, 3) ^ w_b;
    assign w_t1  = w_t0 ^ rotr(w_t0, 1);
    assign o_new = CONST_C ^ {{(WORD_W-1){1'b0}}, i_z} ^ w_src ^ w_t1;

endmodule

// File: rtl/simon32_64_dec.sv
// Iterative Simon 32/64 decryption core: expands the key schedule forward, then runs
// the rounds backwards while regenerating earlier round keys from a 4-word window.
module simon32_64_dec
    import simon_pkg::*;
#(
    parameter int NUM_ROUNDS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] ciphertext,
    input  logic [63:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] plaintext,
    output logic        busy,
    output state_t      o_dbg_state,
    output logic [63:0] o_dbg_key_window
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // out_valid/plaintext stay stable until that transfer, in_ready is high only in IDLE.

    localparam logic [5:0] LAST_I = 6'(NUM_ROUNDS - 5);
    localparam logic [5:0] LAST_J = 6'(NUM_ROUNDS - 1);

    state_t      r_state;
    state_t      w_next_state;
    word_t       r_x;
    word_t       r_y;
    word_t       r_w3;
    word_t       r_w2;
    word_t       r_w1;
    word_t       r_w0;
    logic [5:0]  r_i;
    logic [5:0]  r_j;
    logic        r_out_valid;
    logic [31:0] r_plaintext;

    logic        w_inverse;
    logic [5:0]  w_z_idx;
    logic        w_z;
    word_t       w_new_key;
    word_t       w_round_x;
    word_t       w_round_y;

    assign w_inverse = (r_state == DECRYPT);
    assign w_z_idx   = w_inverse ? (r_j - 6'd4) : r_i;
    assign w_z       = z_bit(w_z_idx);

    simon_keysched_step u_keystep (
        .i_inverse (w_inverse),
        .i_w3      (r_w3),
        .i_w2      (r_w2),
        .i_w1      (r_w1),
        .i_w0      (r_w0),
        .i_z       (w_z),
        .o_new     (w_new_key)
    );

    assign w_round_x = r_y;
    assign w_round_y = r_x ^ simon_f(r_y) ^ r_w3;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid)        w_next_state = EXPAND;
            EXPAND:  if (r_i == LAST_I)   w_next_state = DECRYPT;
            DECRYPT: if (r_j == 6'd0)     w_next_state = DONE;
            DONE:    if (out_ready)       w_next_state = IDLE;
            default:                      w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_w3        <= '0;
            r_w2        <= '0;
            r_w1        <= '0;
            r_w0        <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_out_valid <= 1'b0;
            r_plaintext <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x                      <= ciphertext[31:16];
                        r_y                      <= ciphertext[15:0];
                        {r_w3, r_w2, r_w1, r_w0} <= key;
                        r_i                      <= '0;
                    end
                end
                EXPAND: begin
                    {r_w3, r_w2, r_w1, r_w0} <= {w_new_key, r_w3, r_w2, r_w1};
                    r_i                      <= r_i + 6'd1;
                    if (r_i == LAST_I) begin
                        r_j <= LAST_J;
                    end
                end
                DECRYPT: begin
                    r_x <= w_round_x;
                    r_y <= w_round_y;
                    // Below j=4 no new key exists, but the window still slides so that
                    // w3 presents k[j-1] for the next round.
                    {r_w3, r_w2, r_w1} <= {r_w2, r_w1, r_w0};
                    if (r_j >= 6'd4) begin
                        r_w0 <= w_new_key;
                    end
                    if (r_j != 6'd0) begin
                        r_j <= r_j - 6'd1;
                    end else begin
                        r_plaintext <= {w_round_x, w_round_y};
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready         = (r_state == IDLE);
    assign busy             = (r_state == EXPAND) || (r_state == DECRYPT);
    assign out_valid        = r_out_valid;
    assign plaintext        = r_plaintext;
    assign o_dbg_state      = r_state;
    assign o_dbg_key_window = {r_w3, r_w2, r_w1, r_w0};

endmodule
